// File: rtl/msrv32_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_fetch_ctrl
//  Description : Instruction fetch sequencer for the msrv32 core. Holds the
//                architectural PC, drives the PC mux select and the AHB-lite
//                instruction address phase, captures redirects during bus
//                wait states and kills wrong-path words already in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] pc_mux_in,
    input  logic        trap_in,
    input  logic        mret_in,
    input  logic        branch_taken_in,
    input  logic        stall_in,
    input  logic        ahb_ready_in,
    output logic [1:0]  pc_src_out,
    output logic [31:0] pc_out,
    output logic [31:0] iaddr_out,
    output logic [1:0]  htrans_out,
    output logic        instr_valid_out,
    output logic        flush_out
);

    // FSM encoding
    localparam logic [1:0] C_ST_BOOT  = 2'd0;
    localparam logic [1:0] C_ST_FETCH = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_HOLD  = 2'd3;

    // PC mux select codes; C_SRC_BOOT doubles as "no pending redirect"
    localparam logic [1:0] C_SRC_BOOT = 2'b00;
    localparam logic [1:0] C_SRC_EPC  = 2'b01;
    localparam logic [1:0] C_SRC_TRAP = 2'b10;
    localparam logic [1:0] C_SRC_NEXT = 2'b11;

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

    localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    logic [1:0]  state_q,       state_d;
    logic [3:0]  boot_cnt_q,    boot_cnt_d;
    logic [31:0] pc_q,          pc_d;
    logic [1:0]  pend_q,        pend_d;
    logic        outstanding_q, outstanding_d;
    logic        kill_q,        kill_d;

    logic [1:0]  w_new_code;
    logic [1:0]  w_redir_code;
    logic        w_active;
    logic        w_addr_phase;
    logic        w_redir;
    logic        w_apply;
    logic        w_latch;
    logic        w_accept;
    logic        w_beat;

    // Priority rank of a redirect code: trap > mret > branch > none
    function automatic logic [1:0] code_rank(input logic [1:0] code);
        logic [1:0] rank;
        case (code)
            C_SRC_TRAP: rank = 2'd3;
            C_SRC_EPC:  rank = 2'd2;
            C_SRC_NEXT: rank = 2'd1;
            default:    rank = 2'd0;
        endcase
        return rank;
    endfunction

    // Redirect arbitration and bus handshake qualifiers
    always_comb begin
        w_new_code = trap_in         ? C_SRC_TRAP :
                     mret_in         ? C_SRC_EPC  :
                     branch_taken_in ? C_SRC_NEXT : C_SRC_BOOT;
        // A latched redirect competes with new events; the stronger one wins
        w_redir_code = (code_rank(pend_q) >= code_rank(w_new_code)) ? pend_q : w_new_code;
        w_active     = (state_q != C_ST_BOOT);
        w_addr_phase = (state_q == C_ST_FETCH) || (state_q == C_ST_WAIT);
        w_redir      = w_active && (w_redir_code != C_SRC_BOOT);
        w_apply      = w_redir && ahb_ready_in;
        w_latch      = w_redir && !ahb_ready_in;
        // A redirect overrides a decode stall; the NONSEQ on the bus is taken
        w_accept     = w_addr_phase && ahb_ready_in && (w_apply || !stall_in);
        w_beat       = ahb_ready_in && outstanding_q;
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= C_ST_BOOT;
            boot_cnt_q    <= 4'd0;
            pc_q          <= BOOT_ADDRESS;
            pend_q        <= C_SRC_BOOT;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_BOOT: begin
                if (boot_cnt_q == C_BOOT_LAST) begin
                    state_d = C_ST_FETCH;
                end
            end
            C_ST_FETCH, C_ST_WAIT: begin
                // HREADY low must keep the address phase stable, so it beats stall
                if (w_apply) begin
                    state_d = C_ST_FETCH;
                end else if (!ahb_ready_in) begin
                    state_d = C_ST_WAIT;
                end else if (stall_in) begin
                    state_d = C_ST_HOLD;
                end else begin
                    state_d = C_ST_FETCH;
                end
            end
            C_ST_HOLD: begin
                if (w_apply || !stall_in) begin
                    state_d = C_ST_FETCH;
                end
            end
            default: state_d = C_ST_BOOT;
        endcase
    end

    // Datapath next values: boot counter, PC, pending redirect, in-flight tracking
    always_comb begin
        boot_cnt_d = (state_q == C_ST_BOOT) ? boot_cnt_q + 4'd1 : boot_cnt_q;
        pc_d       = (w_apply || w_accept) ? pc_mux_in : pc_q;

        pend_d = pend_q;
        if (w_apply) begin
            pend_d = C_SRC_BOOT;
        end else if (w_latch) begin
            pend_d = w_redir_code;
        end

        outstanding_d = outstanding_q;
        if (w_accept) begin
            outstanding_d = 1'b1;
        end else if (w_beat) begin
            outstanding_d = 1'b0;
        end

        // The address taken on the redirect cycle belongs to the old path
        kill_d = kill_q;
        if (w_apply && w_addr_phase) begin
            kill_d = 1'b1;
        end else if (w_latch && outstanding_q) begin
            kill_d = 1'b1;
        end else if (w_beat) begin
            kill_d = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        if (!w_active) begin
            pc_src_out = C_SRC_BOOT;
        end else if (w_redir) begin
            pc_src_out = w_redir_code;
        end else begin
            pc_src_out = C_SRC_NEXT;
        end
        htrans_out      = w_addr_phase ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
        instr_valid_out = w_beat && !kill_q && !w_apply;
        flush_out       = w_apply;
        pc_out          = pc_q;
        iaddr_out       = pc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrv32_fetch_ctrl
//  Description : Self-checking bench for msrv32_fetch_ctrl with directed
//                scenarios followed by randomized bus/redirect traffic,
//                compared cycle by cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_fetch_ctrl;

    localparam logic [31:0] C_BOOT_A = 32'h0000_0000;
    localparam int          C_BOOT_N = 4;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic [31:0] pc_mux_in;
    logic        trap_in, mret_in, branch_taken_in, stall_in, ahb_ready_in;
    logic [1:0]  pc_src_out;
    logic [31:0] pc_out, iaddr_out;
    logic [1:0]  htrans_out;
    logic        instr_valid_out, flush_out;

    always #5 clk = ~clk;

    msrv32_fetch_ctrl #(
        .BOOT_ADDRESS (C_BOOT_A),
        .BOOT_CYCLES  (C_BOOT_N)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n_in),
        .pc_mux_in       (pc_mux_in),
        .trap_in         (trap_in),
        .mret_in         (mret_in),
        .branch_taken_in (branch_taken_in),
        .stall_in        (stall_in),
        .ahb_ready_in    (ahb_ready_in),
        .pc_src_out      (pc_src_out),
        .pc_out          (pc_out),
        .iaddr_out       (iaddr_out),
        .htrans_out      (htrans_out),
        .instr_valid_out (instr_valid_out),
        .flush_out       (flush_out)
    );

    int n_chk = 0;
    int n_err = 0;
    int flush_cnt = 0;

    // PC mux targets supplied by the surrounding core
    logic [31:0] tgt_epc  = 32'h80;
    logic [31:0] tgt_trap = 32'h200;
    logic [31:0] tgt_br   = 32'h100;

    // Behavioural model state
    int          m_boot_left;
    bit          m_hold;
    bit          m_inflight;
    bit          m_kill;
    int          m_pend;      // 0 none, 1 branch, 2 mret, 3 trap
    logic [31:0] m_pc;

    // Per-cycle model products
    int          m_rank;
    bit          m_apply, m_beat;
    logic [1:0]  e_src, e_htrans;
    bit          e_valid, e_flush;

    // Last sampled DUT outputs for directed checks
    logic [1:0]  l_src, l_htrans;
    logic [31:0] l_iaddr;
    logic        l_valid, l_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot_left = C_BOOT_N;
        m_hold      = 1'b0;
        m_inflight  = 1'b0;
        m_kill      = 1'b0;
        m_pend      = 0;
        m_pc        = C_BOOT_A;
    endtask

    // Expected combinational outputs for the current cycle and the PC mux value
    task automatic model_eval(input bit tr, input bit mr, input bit br, input bit rd);
        int nr;
        bit booting;
        booting = (m_boot_left > 0);
        nr      = tr ? 3 : (mr ? 2 : (br ? 1 : 0));
        m_rank  = booting ? 0 : ((m_pend > nr) ? m_pend : nr);
        if (booting)          e_src = 2'b00;
        else if (m_rank == 3) e_src = 2'b10;
        else if (m_rank == 2) e_src = 2'b01;
        else                  e_src = 2'b11;
        e_htrans = (booting || m_hold) ? 2'b00 : 2'b10;
        m_apply  = (m_rank > 0) && rd;
        m_beat   = rd && m_inflight;
        e_valid  = m_beat && !m_kill && !m_apply;
        e_flush  = m_apply;
        case (e_src)
            2'b00:   pc_mux_in = C_BOOT_A;
            2'b01:   pc_mux_in = tgt_epc;
            2'b10:   pc_mux_in = tgt_trap;
            default: pc_mux_in = (m_rank == 1) ? tgt_br : m_pc + 32'd4;
        endcase
    endtask

    // Advance the model by one clock
    task automatic model_step(input bit st, input bit rd);
        bit issuing, latching, new_hold;
        if (m_boot_left > 0) begin
            m_boot_left--;
            return;
        end
        issuing  = !m_hold && rd && (m_apply || !st);
        latching = (m_rank > 0) && !rd;
        new_hold = m_apply ? 1'b0 : (m_hold ? st : (rd && st));
        if (m_apply || issuing) m_pc = pc_mux_in;
        if (m_apply)                     m_kill = !m_hold;
        else if (latching && m_inflight) m_kill = 1'b1;
        else if (m_beat)                 m_kill = 1'b0;
        if (issuing)     m_inflight = 1'b1;
        else if (m_beat) m_inflight = 1'b0;
        if (m_apply)       m_pend = 0;
        else if (latching) m_pend = m_rank;
        m_hold = new_hold;
    endtask

    // One clock: drive inputs, compare at negedge, advance model at posedge
    task automatic cycle(input bit tr, input bit mr, input bit br, input bit st, input bit rd);
        trap_in         = tr;
        mret_in         = mr;
        branch_taken_in = br;
        stall_in        = st;
        ahb_ready_in    = rd;
        model_eval(tr, mr, br, rd);
        @(negedge clk);
        l_src    = pc_src_out;
        l_htrans = htrans_out;
        l_iaddr  = iaddr_out;
        l_valid  = instr_valid_out;
        l_flush  = flush_out;
        chk("pc_src", {30'd0, pc_src_out}, {30'd0, e_src});
        chk("pc", pc_out, m_pc);
        chk("iaddr", iaddr_out, m_pc);
        chk("htrans", {30'd0, htrans_out}, {30'd0, e_htrans});
        chk("instr_valid", {31'd0, instr_valid_out}, {31'd0, e_valid});
        chk("flush", {31'd0, flush_out}, {31'd0, e_flush});
        if (flush_out) flush_cnt++;
        @(posedge clk);
        model_step(st, rd);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"},     pc_out, C_BOOT_A);
        chk({tag, "_iaddr"},  iaddr_out, C_BOOT_A);
        chk({tag, "_src"},    {30'd0, pc_src_out}, 32'd0);
        chk({tag, "_htrans"}, {30'd0, htrans_out}, 32'd0);
        chk({tag, "_valid"},  {31'd0, instr_valid_out}, 32'd0);
        chk({tag, "_flush"},  {31'd0, flush_out}, 32'd0);
    endtask

    initial begin
        rst_n_in        = 1'b0;
        pc_mux_in       = 32'd0;
        trap_in         = 1'b0;
        mret_in         = 1'b0;
        branch_taken_in = 1'b0;
        stall_in        = 1'b0;
        ahb_ready_in    = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n_in = 1'b1;

        // Boot window: four idle cycles with select 00
        for (int i = 0; i < C_BOOT_N; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("boot_htrans", {30'd0, l_htrans}, 32'd0);
            chk("boot_src", {30'd0, l_src}, 32'd0);
        end
        // First NONSEQ at the boot address on cycle 5
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_htrans", {30'd0, l_htrans}, 32'h2);
        chk("first_iaddr", l_iaddr, 32'h0);
        // Sequential stream
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("seq_iaddr", l_iaddr, 32'(4 * k));
            chk("seq_valid", {31'd0, l_valid}, 32'd1);
        end
        // Branch with a beat in flight
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("br_flush", {31'd0, l_flush}, 32'd1);
        chk("br_valid", {31'd0, l_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br_target", l_iaddr, 32'h100);
        chk("br_kill", {31'd0, l_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br_resume", {31'd0, l_valid}, 32'd1);
        // Trap and branch together
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("trap_src", {30'd0, l_src}, 32'h2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("trap_pc", l_iaddr, 32'h200);
        // HREADY low for three cycles, mret in the second
        flush_cnt = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait_iaddr1", l_iaddr, 32'h204);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wait_iaddr2", l_iaddr, 32'h204);
        chk("wait_src", {30'd0, l_src}, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait_iaddr3", l_iaddr, 32'h204);
        chk("pend_src", {30'd0, l_src}, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mret_flush", {31'd0, l_flush}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mret_pc", l_iaddr, 32'h80);
        chk("mret_kill", {31'd0, l_valid}, 32'd0);
        chk("flush_count", flush_cnt, 32'd1);
        // Decode stall for two cycles
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stall_iaddr1", l_iaddr, 32'h84);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stall_htrans", {30'd0, l_htrans}, 32'd0);
        chk("stall_iaddr2", l_iaddr, 32'h84);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Asynchronous reset in the middle of a WAIT cycle with a trap pending
        trap_in      = 1'b1;
        ahb_ready_in = 1'b1;
        pc_mux_in    = tgt_trap;
        #2 rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        trap_in = 1'b0;
        @(posedge clk);
        #1 rst_n_in = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(63) == 0) begin
                tgt_epc  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
                tgt_br   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
                tgt_trap = ($urandom_range(1) == 0) ? 32'hFFFF_FFF8 : ({$urandom(), 2'b00} & 32'hFFFF_FFFC);
            end
            cycle($urandom_range(99) < 3, $urandom_range(99) < 4, $urandom_range(99) < 8,
                  $urandom_range(99) < 15, $urandom_range(99) < 75);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
